// File: rtl/muldiv_if.sv
`default_nettype none
// =====================================================================
// muldiv_if : start/busy/done handshake, operands and HI/LO bundle
// Rev 1.0
// =====================================================================
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv.sv
`default_nettype none
// =====================================================================
// muldiv : radix-2 iterative MULT/MULTU/DIV/DIVU into HI/LO, 32 steps.
// Option : define MULDIV_DIV_EN to build the restoring divider. Rev 1.0
// =====================================================================
module muldiv (
    input  logic    clk,
    input  logic    reset_n,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_start_state;
    logic [4:0]  r_count;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic        r_neg_res;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_last;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_msum;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod;

    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_count == 5'd31);
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.a[31];
    assign w_b_neg  = w_signed & bus.b[31];
    assign w_a_mag  = w_a_neg ? (~bus.a + 32'd1) : bus.a;
    assign w_b_mag  = w_b_neg ? (~bus.b + 32'd1) : bus.b;

    // Multiplier magnitude sits in r_acc[31:0] and is consumed LSB first.
    assign w_msum     = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mcand : 32'd0)};
    assign w_acc_next = {w_msum, r_acc[31:1]};
    assign w_prod     = r_neg_res ? (~w_acc_next + 64'd1) : w_acc_next;

`ifdef MULDIV_DIV_EN
    logic        r_op_div;
    logic        r_neg_rem;
    logic        r_dz;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [32:0] w_shift;
    logic        w_borrow;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    // w_shift is the 33-bit partial remainder after shifting in the next dividend bit.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_borrow   = w_shift < {1'b0, r_mcand};
    assign w_rem_next = w_borrow ? w_shift[31:0] : (w_shift[31:0] - r_mcand);
    assign w_quo_next = {r_quo[30:0], ~w_borrow};
    assign w_div_lo   = r_dz ? 32'hFFFF_FFFF
                             : (r_neg_res ? (~w_quo_next + 32'd1) : w_quo_next);
    assign w_div_hi   = r_neg_rem ? (~w_rem_next + 32'd1) : w_rem_next;
    assign w_start_state = S_RUN;
`else
    // Without the divider a DIV/DIVU completes immediately and leaves HI/LO alone.
    assign w_start_state = bus.op[1] ? S_DONE : S_RUN;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = w_start_state;
                end else if (r_state == S_DONE) begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_count == 5'd31) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count   <= 5'd0;
            r_acc     <= 64'd0;
            r_mcand   <= 32'd0;
            r_neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_op_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
`endif
        end else if (w_accept) begin
            r_count   <= 5'd0;
            r_acc     <= {32'd0, w_a_mag};
            r_mcand   <= w_b_mag;
            r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_op_div  <= bus.op[1];
            r_neg_rem <= w_a_neg;
            r_dz      <= (bus.b == 32'd0);
            r_rem     <= 32'd0;
            r_quo     <= w_a_mag;
`endif
        end else if (r_state == S_RUN) begin
            r_count <= r_count + 5'd1;
`ifdef MULDIV_DIV_EN
            if (r_op_div) begin
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end else begin
                r_acc <= w_acc_next;
            end
`else
            r_acc <= w_acc_next;
`endif
        end
    end

    // The final iteration's result goes straight to HI/LO; MTHI/MTLO are locked out during RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_last) begin
`ifdef MULDIV_DIV_EN
            if (r_op_div) begin
                r_hi <= w_div_hi;
                r_lo <= w_div_lo;
            end else begin
                r_hi <= w_prod[63:32];
                r_lo <= w_prod[31:0];
            end
`else
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
`endif
        end else if (r_state != S_RUN) begin
            if (bus.mthi) begin
                r_hi <= bus.wdata;
            end
            if (bus.mtlo) begin
                r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
`timescale 1ns/1ps
// tb_muldiv : directed and random stimulus for muldiv, checked every cycle
// against an arithmetic model of HI/LO, busy and done.
module tb_muldiv;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en   = 1'b0;
    int          cyc      = 0;

    int          m_run;
    bit          m_done;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;

    int          lat, nb;
    bit          seen;
    logic [63:0] res;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, got, exp);
        end
    endtask

    // {hi, lo} that the architecture defines for one operation.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        logic [63:0] out;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        out = 64'd0;
        case (op)
            2'b00: out = 64'(sa * sb);
            2'b01: out = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    out = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        out = {32'd0, 32'h8000_0000};
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                        out = {r[31:0], q[31:0]};
                    end
                end else begin
                    out = {a % b, a / b};
                end
            end
        endcase
        return out;
    endfunction

    always @(posedge clk) begin : model
        bit nd;
        nd = 1'b0;
        cyc++;
        if (!reset_n) begin
            m_run  = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else begin
            if (m_run > 0) begin
                m_run--;
                if (m_run == 0) begin
                    m_hi = m_res_hi;
                    m_lo = m_res_lo;
                    nd   = 1'b1;
                end
            end else begin
                if (bus.mthi) m_hi = bus.wdata;
                if (bus.mtlo) m_lo = bus.wdata;
                if (bus.start) begin
                    {m_res_hi, m_res_lo} = ref_result(bus.op, bus.a, bus.b);
`ifdef MULDIV_DIV_EN
                    m_run = 32;
`else
                    if (bus.op[1]) nd = 1'b1;
                    else           m_run = 32;
`endif
                end
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_run > 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("hi", bus.hi, m_hi);
            check("lo", bus.lo, m_lo);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
    endtask

    // Cycles from the accept edge to done being visible, counting the accept cycle.
    task automatic wait_done(output int l, output int nbusy);
        l = 1;
        nbusy = 0;
        while (!bus.done && l < 40) begin
            if (bus.busy) nbusy++;
            step();
            l++;
        end
        if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
        reset_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        res = ref_result(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("model_div_lo", res[31:0], 32'hFFFF_FFFD);
        check("model_div_hi", res[63:32], 32'hFFFF_FFFF);
        res = ref_result(2'b00, 32'hFFFF_FFFD, 32'd5);
        check("model_mult", res[31:0], 32'hFFFF_FFF1);

        reset_n = 1'b1;
        step();

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, nb);
        check("mult_latency", lat, 32'd33);
        check("mult_busy_cycles", nb, 32'd32);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFF1);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, nb);
`ifdef MULDIV_DIV_EN
        check("div_latency", lat, 32'd33);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
`else
        check("div_off_latency", lat, 32'd1);
        check("div_off_busy", nb, 32'd0);
        check("div_off_hi", bus.hi, 32'hFFFF_FFFE);
        check("div_off_lo", bus.lo, 32'h0000_0001);
`endif

        issue(2'b11, 32'd100, 32'd0);
        wait_done(lat, nb);
`ifdef MULDIV_DIV_EN
        check("divu0_hi", bus.hi, 32'h0000_0064);
        check("divu0_lo", bus.lo, 32'hFFFF_FFFF);
`else
        check("divu0_off_latency", lat, 32'd1);
        check("divu0_off_lo", bus.lo, 32'h0000_0001);
`endif

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, nb);
`ifdef MULDIV_DIV_EN
        check("divovf_hi", bus.hi, 32'd0);
        check("divovf_lo", bus.lo, 32'h8000_0000);
`else
        check("divovf_off_busy", nb, 32'd0);
        check("divovf_off_hi", bus.hi, 32'hFFFF_FFFE);
`endif

        step();
        step();
        issue(2'b01, 32'd7, 32'd6);
        repeat (9) step();
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd1; bus.b = 32'd1;
        bus.mtlo = 1'b1; bus.wdata = 32'h1234;
        step();
        bus.start = 1'b0; bus.mtlo = 1'b0;
        wait_done(lat, nb);
        check("ignore_hi", bus.hi, 32'd0);
        check("ignore_lo", bus.lo, 32'd42);
        step();
        bus.mthi = 1'b1; bus.wdata = 32'hABCD;
        step();
        bus.mthi = 1'b0;
        check("mthi_hi", bus.hi, 32'h0000_ABCD);

        issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (19) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            seen |= bus.done;
            step();
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        issue(2'b01, 32'd3, 32'd4);
        wait_done(lat, nb);
        check("after_rst_latency", lat, 32'd33);
        check("after_rst_lo", bus.lo, 32'd12);

        for (int t = 0; t < 60; t++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            bus.mthi  = ($urandom_range(0, 3) == 0);
            bus.mtlo  = ($urandom_range(0, 3) == 0);
            bus.wdata = $urandom;
            issue(rop, ra, rb);
            bus.mthi = 1'b0;
            bus.mtlo = 1'b0;
            for (int k = 0; k < 40 && !bus.done; k++) begin
                bus.start = ($urandom_range(0, 7) == 0);
                bus.op    = 2'($urandom_range(0, 3));
                bus.a     = $urandom;
                bus.b     = $urandom;
                bus.mthi  = ($urandom_range(0, 7) == 0);
                bus.mtlo  = ($urandom_range(0, 7) == 0);
                bus.wdata = $urandom;
                step();
            end
            bus.start = 1'b0;
            bus.mthi  = 1'b0;
            bus.mtlo  = 1'b0;
            if (!bus.done) check("rand_done_timeout", 32'(bus.done), 32'd1);
            repeat ($urandom_range(0, 2)) step();
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
